mag_debounce_steer: RTL and testbench
=====================================

Name: mag_debounce_steer

Overview:
- Parametrised successor to the 4-sensor magnetic tape switch block.
- Synchronises and debounces NUM_CH magnetic sensor inputs, each channel with its own counter, with selectable sensor polarity.
- Feeds the debounced vector into a registered steering FSM with a timed stop/resume rule.
- Sits between the sensor pins and the main drive module; drives the 4-bit direction code consumed by the motor controller.

Parameters:
- NUM_CH, 4, number of sensor channels; must be even and >= 2. Channels [NUM_CH/2-1:0] are right-side sensors; channels [NUM_CH-1:NUM_CH/2] are left-side sensors.
- CNT_W, 25, width of each debounce counter and of the resume counter.
- DEBOUNCE_CYCLES, 12_500_000, consecutive mismatch cycles required before a channel's stable value flips (500 ms at 25 MHz). Range 1..2^CNT_W-1.
- RESUME_CYCLES, 12_500_000, consecutive all-inactive cycles required to leave STOP. Range 1..2^CNT_W-1.
- ACTIVE_LOW, 1, 1 = sensor pin low means magnet present; 0 = pin high means magnet present.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, synchronous active-low reset.
- en, input, 1, steering enable; 0 forces STOP.
- sens, input, NUM_CH, raw asynchronous sensor pins.
- stable, output, NUM_CH, debounced active-high "magnet present" vector.
- chg, output, NUM_CH, one-cycle pulse on the cycle a channel's stable bit flips.
- dir, output, 4, direction code to main module.
- state, output, 2, FSM state: 00 FWD, 01 VEER_L, 10 VEER_R, 11 STOP.
- stop_evt, output, 1, one-cycle pulse on the cycle state enters STOP.

Behaviour:
- Reset (rst_n=0 at posedge clk), all registers cleared:
  - sync flops = inactive level; stable=0; chg=0; all counters=0.
  - state=STOP; dir=4'b1111; stop_evt=0.
- Input conditioning:
  - 2-flop synchroniser per channel.
  - Polarity is applied after the synchroniser: act = ACTIVE_LOW ? ~sync2 : sync2.
- Debounce, per channel, independent:
  - If act != stable: cnt <= cnt+1.
  - When cnt == DEBOUNCE_CYCLES-1 and act != stable: stable <= act, cnt <= 0, chg pulses that same cycle.
  - If act == stable: cnt <= 0. Any single-cycle match restarts the count.
  - Latency from a sens edge to the stable flip is exactly 2 + DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES never propagate.
- Group decode (combinational from stable):
  - L = OR of the left half.
  - R = OR of the right half.
- FSM (registered; state updates one cycle after stable changes):
  - en=0 from any state -> STOP; resume counter held at 0.
  - FWD: L&R -> STOP; L only -> VEER_L; R only -> VEER_R; neither -> stay.
  - VEER_L: L&R -> STOP; R only -> VEER_R; neither -> FWD; L only -> stay.
  - VEER_R: mirror of VEER_L.
  - STOP:
    - rcnt increments while en=1 and L=0 and R=0; any active channel clears rcnt.
    - When rcnt == RESUME_CYCLES-1 with the same conditions true: -> FWD, rcnt <= 0.
    - L or R alone never exits STOP.
- dir is decoded from state, valid the same cycle as state: FWD=0000, VEER_L=0101, VEER_R=1001, STOP=1111.
- stop_evt pulses when the state transitions into STOP from a non-STOP state, including via en=0. It does not pulse out of reset or while already in STOP.
- Simultaneous events:
  - Both groups becoming active in the same cycle -> STOP (stop has priority over veer).
  - en=0 has priority over all transitions.
- Reset mid-debounce discards the partial count; the channel restarts from stable=0.
- Counters never wrap: each counter clears at its terminal value, and it clears on any match.

Test Plan (NUM_CH=4, DEBOUNCE_CYCLES=4, RESUME_CYCLES=8, ACTIVE_LOW=1):
- Reset release with sens=4'b1111, en=1: state=STOP, dir=1111. After 8 idle cycles: state=FWD, dir=0000, no stop_evt.
- From FWD, sens[2]=0 held: stable[2]=1 and chg[2]=1 exactly 6 cycles after the edge. Next cycle state=VEER_L, dir=0101.
- From FWD, sens[0] low for 3 cycles, then high: stable, chg and state never change.
- In VEER_L, drive sens[0]=0 while sens[2] is still low: after debounce, state=STOP, dir=1111, stop_evt=1 for one cycle.
- In STOP, release all sensors with one 1-cycle blip on sens[1] mid-resume: rcnt does not restart, because the blip is filtered by debounce. FWD is reached 8 cycles after the stable vector reaches 0.
- In VEER_R, drop en: next cycle state=STOP, stop_evt=1. Reassert en with sensors inactive: FWD after 8 cycles. Assert rst_n=0 mid-debounce: stable=0 and all counters reset.

Source files
------------

// File: rtl/mag_debounce_steer.sv
`default_nettype none
// ============================================================================
// Module      : mag_debounce_steer
// Description : Synchronises and debounces NUM_CH magnetic tape sensors with
//               selectable polarity, then steers a registered FWD / VEER_L /
//               VEER_R / STOP machine with a timed resume out of STOP.
// Revision    : 1.0  initial release
// ============================================================================
module mag_debounce_steer #(
  parameter int NUM_CH          = 4,
  parameter int CNT_W           = 25,
  parameter int DEBOUNCE_CYCLES = 12_500_000,
  parameter int RESUME_CYCLES   = 12_500_000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NUM_CH-1:0] sens,
  output logic [NUM_CH-1:0] stable,
  output logic [NUM_CH-1:0] chg,
  output logic [3:0]        dir,
  output logic [1:0]        state,
  output logic              stop_evt
);

  // Synchroniser reset value is the pin level that means "no magnet".
  localparam logic [NUM_CH-1:0] SYNC_IDLE = {NUM_CH{ACTIVE_LOW}};
  localparam logic [CNT_W-1:0]  DB_TERM   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RS_TERM   = CNT_W'(RESUME_CYCLES - 1);

  localparam logic [3:0] DIR_FWD    = 4'b0000;
  localparam logic [3:0] DIR_VEER_L = 4'b0101;
  localparam logic [3:0] DIR_VEER_R = 4'b1001;
  localparam logic [3:0] DIR_STOP   = 4'b1111;

  typedef enum logic [1:0] {
    ST_FWD    = 2'b00,
    ST_VEER_L = 2'b01,
    ST_VEER_R = 2'b10,
    ST_STOP   = 2'b11
  } state_t;

  // --------------------------------------------------------------------------
  // Input conditioning and per-channel debounce
  // --------------------------------------------------------------------------
  logic [NUM_CH-1:0] sync1_q, sync2_q;
  logic [NUM_CH-1:0] act;
  logic [NUM_CH-1:0] stable_q, stable_d;
  logic [NUM_CH-1:0] chg_q, chg_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];

  // Polarity fold, then each channel counts consecutive mismatches; any match restarts it.
  always_comb begin
    act = ACTIVE_LOW ? ~sync2_q : sync2_q;
    for (int i = 0; i < NUM_CH; i++) begin
      stable_d[i] = stable_q[i];
      chg_d[i]    = 1'b0;
      cnt_d[i]    = '0;
      if (act[i] != stable_q[i]) begin
        if (cnt_q[i] == DB_TERM) begin
          stable_d[i] = act[i];
          chg_d[i]    = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Synchroniser chain and debounce state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= SYNC_IDLE;
      sync2_q  <= SYNC_IDLE;
      stable_q <= '0;
      chg_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= sens;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      chg_q    <= chg_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Group decode and steering FSM
  // --------------------------------------------------------------------------
  logic             grp_l, grp_r;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [3:0]       dir_q, dir_d;
  logic             stop_evt_q, stop_evt_d;

  assign grp_l = |stable_q[NUM_CH-1:NUM_CH/2];
  assign grp_r = |stable_q[NUM_CH/2-1:0];

  // Next state: en low wins, both groups wins over veer, STOP needs a quiet window to exit.
  always_comb begin
    state_d = state_q;
    rcnt_d  = '0;
    if (!en) begin
      state_d = ST_STOP;
    end else begin
      case (state_q)
        ST_FWD: begin
          if (grp_l && grp_r) state_d = ST_STOP;
          else if (grp_l)     state_d = ST_VEER_L;
          else if (grp_r)     state_d = ST_VEER_R;
        end
        ST_VEER_L: begin
          if (grp_l && grp_r) state_d = ST_STOP;
          else if (grp_r)     state_d = ST_VEER_R;
          else if (!grp_l)    state_d = ST_FWD;
        end
        ST_VEER_R: begin
          if (grp_l && grp_r) state_d = ST_STOP;
          else if (grp_l)     state_d = ST_VEER_L;
          else if (!grp_r)    state_d = ST_FWD;
        end
        default: begin
          if (!grp_l && !grp_r) begin
            if (rcnt_q == RS_TERM) state_d = ST_FWD;
            else                   rcnt_d  = rcnt_q + 1'b1;
          end
        end
      endcase
    end

    case (state_d)
      ST_FWD:    dir_d = DIR_FWD;
      ST_VEER_L: dir_d = DIR_VEER_L;
      ST_VEER_R: dir_d = DIR_VEER_R;
      default:   dir_d = DIR_STOP;
    endcase

    stop_evt_d = (state_d == ST_STOP) && (state_q != ST_STOP);
  end

  // FSM state, resume counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_STOP;
      rcnt_q     <= '0;
      dir_q      <= DIR_STOP;
      stop_evt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rcnt_q     <= rcnt_d;
      dir_q      <= dir_d;
      stop_evt_q <= stop_evt_d;
    end
  end

  assign stable   = stable_q;
  assign chg      = chg_q;
  assign dir      = dir_q;
  assign state    = state_q;
  assign stop_evt = stop_evt_q;

endmodule
`default_nettype wire

// File: tb/tb_mag_debounce_steer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mag_debounce_steer
// Description : Directed scoreboard bench for mag_debounce_steer
//               (NUM_CH=4, DEBOUNCE_CYCLES=4, RESUME_CYCLES=8, ACTIVE_LOW=1).
// Revision    : 1.0  initial release
// ============================================================================
module tb_mag_debounce_steer;

  localparam logic [1:0] S_FWD = 2'b00, S_VL = 2'b01, S_VR = 2'b10, S_STOP = 2'b11;
  localparam logic [3:0] D_FWD = 4'b0000, D_VL = 4'b0101, D_VR = 4'b1001, D_STOP = 4'b1111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] sens;
  logic [3:0] stable, chg, dir;
  logic [1:0] state;
  logic       stop_evt;

  mag_debounce_steer #(
    .NUM_CH(4), .CNT_W(25), .DEBOUNCE_CYCLES(4), .RESUME_CYCLES(8), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sens(sens),
    .stable(stable), .chg(chg), .dir(dir), .state(state), .stop_evt(stop_evt)
  );

  always #5 clk = ~clk;

  // Posedge counter used to time-stamp expectations.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [3:0] stb;
    logic [3:0] chg;
    logic [1:0] st;
    logic [3:0] dr;
    logic       se;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Schedule an expected output snapshot d cycles from now.
  task automatic push_exp(input int d, input logic [3:0] stb, input logic [3:0] ch,
                          input logic [1:0] st, input logic [3:0] dr, input logic se,
                          input string nm);
    exp_t e;
    e.c = cyc + d; e.stb = stb; e.chg = ch; e.st = st; e.dr = dr; e.se = se; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compare every scoreboard entry that falls due on this cycle.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].c == cyc) begin
          n_checks++;
          if ({stable, chg, state, dir, stop_evt} !== {q[i].stb, q[i].chg, q[i].st, q[i].dr, q[i].se}) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got stable=%b chg=%b state=%b dir=%b stop_evt=%b, want stable=%b chg=%b state=%b dir=%b stop_evt=%b",
                     q[i].nm, cyc, stable, chg, state, dir, stop_evt,
                     q[i].stb, q[i].chg, q[i].st, q[i].dr, q[i].se);
          end
          q.delete(i);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    sens  = 4'b1111;
    step(3);

    // Reset state, then timed resume out of STOP with all sensors idle.
    push_exp(0, 4'b0000, 4'b0000, S_STOP, D_STOP, 1'b0, "reset_state");
    rst_n = 1'b1;
    push_exp(7, 4'b0000, 4'b0000, S_STOP, D_STOP, 1'b0, "resume_not_yet");
    push_exp(8, 4'b0000, 4'b0000, S_FWD,  D_FWD,  1'b0, "resume_fwd");
    step(10);
    n_checks++;
    if (state !== S_FWD || dir !== D_FWD) begin
      n_err++;
      $display("FAIL direct_fwd_after_resume: state=%b dir=%b", state, dir);
    end

    // 3-cycle glitch on a right sensor must be filtered.
    sens = 4'b1110;
    push_exp(3, 4'b0000, 4'b0000, S_FWD, D_FWD, 1'b0, "glitch_a");
    push_exp(6, 4'b0000, 4'b0000, S_FWD, D_FWD, 1'b0, "glitch_b");
    push_exp(9, 4'b0000, 4'b0000, S_FWD, D_FWD, 1'b0, "glitch_c");
    step(3);
    sens = 4'b1111;
    step(10);
    n_checks++;
    if (stable !== 4'b0000 || state !== S_FWD) begin
      n_err++;
      $display("FAIL direct_glitch_filtered: stable=%b state=%b", stable, state);
    end

    // Left sensor held: flips at edge+6, FSM veers left the cycle after.
    sens = 4'b1011;
    push_exp(5, 4'b0000, 4'b0000, S_FWD, D_FWD, 1'b0, "left_before_flip");
    push_exp(6, 4'b0100, 4'b0100, S_FWD, D_FWD, 1'b0, "left_flip");
    push_exp(7, 4'b0100, 4'b0000, S_VL,  D_VL,  1'b0, "veer_l");
    step(8);
    n_checks++;
    if (state !== S_VL || dir !== D_VL) begin
      n_err++;
      $display("FAIL direct_veer_l_held: state=%b dir=%b", state, dir);
    end

    // Right sensor too: both groups active -> STOP with one stop_evt.
    sens = 4'b1010;
    push_exp(6, 4'b0101, 4'b0001, S_VL,   D_VL,   1'b0, "right_flip_in_vl");
    push_exp(7, 4'b0101, 4'b0000, S_STOP, D_STOP, 1'b1, "stop_enter");
    push_exp(8, 4'b0101, 4'b0000, S_STOP, D_STOP, 1'b0, "stop_evt_one_shot");
    step(9);

    // Release all, with a 1-cycle blip mid-resume; FWD 8 cycles after stable=0.
    sens = 4'b1111;
    push_exp(6, 4'b0000, 4'b0101, S_STOP, D_STOP, 1'b0, "release_flip");
    step(8);
    sens = 4'b1101;
    step(1);
    sens = 4'b1111;
    push_exp(3, 4'b0000, 4'b0000, S_STOP, D_STOP, 1'b0, "blip_filtered");
    push_exp(4, 4'b0000, 4'b0000, S_STOP, D_STOP, 1'b0, "resume2_not_yet");
    push_exp(5, 4'b0000, 4'b0000, S_FWD,  D_FWD,  1'b0, "resume2_fwd");
    step(7);

    // Veer right, then drop en -> immediate STOP.
    sens = 4'b1110;
    push_exp(6, 4'b0001, 4'b0001, S_FWD, D_FWD, 1'b0, "right_flip");
    push_exp(7, 4'b0001, 4'b0000, S_VR,  D_VR,  1'b0, "veer_r");
    step(8);
    en = 1'b0;
    push_exp(1, 4'b0001, 4'b0000, S_STOP, D_STOP, 1'b1, "en_drop_stop");
    push_exp(2, 4'b0001, 4'b0000, S_STOP, D_STOP, 1'b0, "en_drop_one_shot");
    step(2);
    n_checks++;
    if (state !== S_STOP || dir !== D_STOP) begin
      n_err++;
      $display("FAIL direct_en_drop_stop: state=%b dir=%b", state, dir);
    end
    sens = 4'b1111;
    push_exp(6, 4'b0000, 4'b0001, S_STOP, D_STOP, 1'b0, "release_while_dis");
    step(10);
    push_exp(0, 4'b0000, 4'b0000, S_STOP, D_STOP, 1'b0, "held_stop_en_low");
    en = 1'b1;
    push_exp(7, 4'b0000, 4'b0000, S_STOP, D_STOP, 1'b0, "resume3_not_yet");
    push_exp(8, 4'b0000, 4'b0000, S_FWD,  D_FWD,  1'b0, "resume3_fwd");
    step(10);

    // Reset mid-debounce discards the partial count.
    sens = 4'b0111;
    step(4);
    rst_n = 1'b0;
    step(1);
    push_exp(0, 4'b0000, 4'b0000, S_STOP, D_STOP, 1'b0, "mid_reset_state");
    rst_n = 1'b1;
    push_exp(5, 4'b0000, 4'b0000, S_STOP, D_STOP, 1'b0, "post_reset_no_early_flip");
    push_exp(6, 4'b1000, 4'b1000, S_STOP, D_STOP, 1'b0, "post_reset_flip");
    push_exp(7, 4'b1000, 4'b0000, S_STOP, D_STOP, 1'b0, "left_alone_stays_stop");
    step(10);
    #2;

    foreach (q[i]) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: check never reached at cyc %0d, want at cyc %0d", q[i].nm, cyc, q[i].c);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
